// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: instruction word plus packed payload, valid/ready handshake, optional 2-entry skid buffer.
// Latency: 1 cycle from accept to out_valid; sustains 1 entry/cycle.
// Backpressure: SKID=1 gives registered in_ready (skid absorbs one extra entry); SKID=0 gives combinational in_ready.
module pipe_stage_reg #(
  parameter int              DW     = 160,
  parameter int              IW     = 32,
  parameter logic [IW-1:0]   NOP_IR = '0,
  parameter int              SKID   = 1,
  parameter int              CW     = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_ir,
  input  logic [DW-1:0] in_data,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_ir,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] stall_cnt
);

  // Main entry drives the outputs; skid only holds the entry that arrived while main was stalled.
  logic          main_vld;
  logic [IW-1:0] main_ir;
  logic [DW-1:0] main_dat;
  logic          skid_vld;
  logic [IW-1:0] skid_ir;
  logic [DW-1:0] skid_dat;
  logic [CW-1:0] stall_q;

  logic accept;
  logic retire;

  // With the skid buffer, in_ready comes straight from skid_vld, so it never depends on out_ready.
  assign in_ready  = (SKID != 0) ? !skid_vld : (!main_vld || out_ready);
  assign accept    = in_valid && in_ready;
  assign retire    = main_vld && out_ready;

  // A bubble always shows the NOP instruction so downstream decode sees nothing to do.
  assign out_valid = main_vld;
  assign out_ir    = main_vld ? main_ir : NOP_IR;
  assign out_data  = main_dat;
  assign stall_cnt = stall_q;

  // Entry storage: flush beats accept; main refills from skid first to keep FIFO order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_vld <= 1'b0;
      main_ir  <= NOP_IR;
      main_dat <= '0;
      skid_vld <= 1'b0;
      skid_ir  <= NOP_IR;
      skid_dat <= '0;
    end else if (flush) begin
      main_vld <= 1'b0;
      main_ir  <= NOP_IR;
      main_dat <= '0;
      skid_vld <= 1'b0;
      skid_ir  <= NOP_IR;
      skid_dat <= '0;
    end else if (!main_vld || retire) begin
      if (skid_vld) begin
        // in_ready was low this cycle, so nothing new can arrive alongside the skid drain
        main_vld <= 1'b1;
        main_ir  <= skid_ir;
        main_dat <= skid_dat;
        skid_vld <= 1'b0;
        skid_ir  <= NOP_IR;
      end else if (accept) begin
        main_vld <= 1'b1;
        main_ir  <= in_ir;
        main_dat <= in_data;
      end else begin
        main_vld <= 1'b0;
        main_ir  <= NOP_IR;
      end
    end else if (accept && (SKID != 0)) begin
      // main is stalled: park the new entry in the skid slot
      skid_vld <= 1'b1;
      skid_ir  <= in_ir;
      skid_dat <= in_data;
    end
  end

  // Saturating count of cycles where a valid entry was held back; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (main_vld && !out_ready && (stall_q != {CW{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance and a no-skid narrow-counter instance share one stimulus stream.
// Each instance is compared against a queue model of the stage's occupancy.
// Directed phases (reset, streaming, backpressure, flush, saturation) then random traffic.
module tb_pipe_stage_reg;

  localparam int DW = 160;
  localparam int IW = 32;
  localparam logic [IW-1:0] NOP = 32'h0000_0000;

  typedef struct {
    logic [IW-1:0] ir;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [IW-1:0] in_ir;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          out_ready;

  logic          a_in_ready, a_out_valid;
  logic [IW-1:0] a_out_ir;
  logic [DW-1:0] a_out_data;
  logic [15:0]   a_stall;

  logic          b_in_ready, b_out_valid;
  logic [IW-1:0] b_out_ir;
  logic [DW-1:0] b_out_data;
  logic [2:0]    b_stall;

  int total = 0;
  int bad   = 0;

  ent_t qa[$];
  ent_t qb[$];
  int   cnt_a, cnt_b;
  bit   zero_a, zero_b;

  pipe_stage_reg #(.DW(DW), .IW(IW), .NOP_IR(NOP), .SKID(1), .CW(16)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_ir(in_ir), .in_data(in_data), .flush(flush), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_ir(a_out_ir), .out_data(a_out_data), .stall_cnt(a_stall)
  );

  pipe_stage_reg #(.DW(DW), .IW(IW), .NOP_IR(NOP), .SKID(0), .CW(3)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_ir(in_ir), .in_data(in_data), .flush(flush), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_ir(b_out_ir), .out_data(b_out_data), .stall_cnt(b_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_clear();
    qa.delete();
    qb.delete();
    cnt_a  = 0;
    cnt_b  = 0;
    zero_a = 1'b1;
    zero_b = 1'b1;
  endtask

  // Compare both instances with the model's view of the current cycle.
  task automatic check_all();
    bit   ev;
    ent_t h;
    ev = (qa.size() > 0);
    if (ev) h = qa[0];
    chk("a_out_valid", a_out_valid, ev);
    chk("a_out_ir", a_out_ir, ev ? h.ir : NOP);
    if (ev) chk("a_out_data", a_out_data, h.d);
    else if (zero_a) chk("a_out_data_zero", a_out_data, '0);
    chk("a_in_ready", a_in_ready, qa.size() < 2);
    chk("a_stall_cnt", a_stall, cnt_a);

    ev = (qb.size() > 0);
    if (ev) h = qb[0];
    chk("b_out_valid", b_out_valid, ev);
    chk("b_out_ir", b_out_ir, ev ? h.ir : NOP);
    if (ev) chk("b_out_data", b_out_data, h.d);
    else if (zero_b) chk("b_out_data_zero", b_out_data, '0);
    chk("b_in_ready", b_in_ready, (qb.size() == 0) || out_ready);
    chk("b_stall_cnt", b_stall, cnt_b);
  endtask

  // Advance the model across one clock edge using the current inputs.
  task automatic model_edge();
    ent_t e;
    bit   acc, ret;
    e.ir = in_ir;
    e.d  = in_data;

    acc = in_valid && (qa.size() < 2);
    ret = (qa.size() > 0) && out_ready;
    if ((qa.size() > 0) && !out_ready && cnt_a < 65535) cnt_a++;
    if (flush) begin
      qa.delete();
      zero_a = 1'b1;
    end else begin
      if (ret) void'(qa.pop_front());
      if (acc) begin
        qa.push_back(e);
        zero_a = 1'b0;
      end else if (ret) begin
        zero_a = 1'b0;
      end
    end

    acc = in_valid && ((qb.size() == 0) || out_ready);
    ret = (qb.size() > 0) && out_ready;
    if ((qb.size() > 0) && !out_ready && cnt_b < 7) cnt_b++;
    if (flush) begin
      qb.delete();
      zero_b = 1'b1;
    end else begin
      if (ret) void'(qb.pop_front());
      if (acc) begin
        qb.push_back(e);
        zero_b = 1'b0;
      end else if (ret) begin
        zero_b = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_a_valid"}, a_out_valid, 1'b0);
    chk({tag, "_a_ir"}, a_out_ir, NOP);
    chk({tag, "_a_data"}, a_out_data, '0);
    chk({tag, "_a_stall"}, a_stall, '0);
    chk({tag, "_b_valid"}, b_out_valid, 1'b0);
    chk({tag, "_b_ir"}, b_out_ir, NOP);
    chk({tag, "_b_data"}, b_out_data, '0);
    chk({tag, "_b_stall"}, b_stall, '0);
  endtask

  task automatic put(input logic [IW-1:0] ir, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_ir    = ir;
    in_data  = d;
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_ir     = '0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    model_clear();

    // asynchronous reset, observed before any clock edge
    #2 reset = 1'b1;
    #1 reset_checks("rst_async");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    cycle();

    // streaming: one entry per cycle, one cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      put(32'h1000_0000 + i, DW'(i));
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    cycle();

    // backpressure: A then B while stalled, then drain
    out_ready = 1'b0;
    put(32'hA000_0001, rnd_data());
    cycle();
    put(32'hB000_0002, rnd_data());
    cycle();
    put(32'hC000_0003, rnd_data());
    cycle();
    cycle();
    cycle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) cycle();

    // flush while main and skid are full, with a simultaneous offer
    out_ready = 1'b0;
    put(32'hA100_0001, rnd_data());
    cycle();
    put(32'hB100_0002, rnd_data());
    cycle();
    put(32'hC100_0003, rnd_data());
    flush = 1'b1;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    cycle();
    out_ready = 1'b1;
    cycle();
    cycle();

    // reset mid-stream with entries held
    out_ready = 1'b0;
    put(32'hD000_0004, rnd_data());
    cycle();
    cycle();
    reset = 1'b1;
    #1 reset_checks("rst_mid");
    model_clear();
    in_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;

    // counter saturation: hold one entry stalled for 10 cycles
    put(32'hE000_0005, rnd_data());
    cycle();
    in_valid = 1'b0;
    repeat (10) cycle();

    // no-skid replace-on-retire: new entry arrives as the stalled one leaves
    out_ready = 1'b1;
    put(32'hF000_0006, rnd_data());
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_ir     = $urandom;
      in_data   = rnd_data();
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      cycle();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (3) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the CPU pipeline (F/D, D/E, E/M, M/W boundaries).
- Carries an instruction word plus a packed payload (PCs, ALU result, memory data, etc.) and uses a valid/ready handshake instead of a bare enable.
- An optional 2-entry skid buffer breaks the combinational ready path.
- A synchronous flush turns the stage into a bubble, and a saturating counter records backpressure cycles.

Parameters:
- DW, 160, payload width in bits; the upstream stage packs its fields into it.
- IW, 32, instruction word width.
- NOP_IR, 32'h00000000, instruction value presented whenever the stage holds no valid entry.
- SKID, 1. When 1: 2-entry skid buffer with a registered in_ready. When 0: single register with a combinational in_ready.
- CW, 16, width of the stall counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream offers an entry.
- in_ready  output  1  stage can accept an entry this cycle.
- in_ir  input  IW  incoming instruction.
- in_data  input  DW  incoming payload.
- flush  input  1  synchronous flush; discards all held entries.
- out_valid  output  1  stage presents a valid entry.
- out_ready  input  1  downstream accepts the entry this cycle.
- out_ir  output  IW  presented instruction; NOP_IR when out_valid=0.
- out_data  output  DW  presented payload; 0 after reset or flush, don't-care when out_valid=0 otherwise.
- stall_cnt  output  CW  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset (async, immediate on assertion):
  - main and skid entries are invalid, both IR fields = NOP_IR, both data fields = 0.
  - stall_cnt = 0.
  - in_ready = 1 from the first edge after deassertion.
- Handshake:
  - Accept occurs when in_valid && in_ready at the edge.
  - Retire occurs when out_valid && out_ready at the edge.
  - out_* are driven from the main entry only.
  - Latency from accept to out_valid is 1 cycle; sustained throughput is 1 entry/cycle.
  - Entries leave in strict FIFO order.
  - out_ir/out_data are held stable while out_valid && !out_ready.
- SKID=1 datapath:
  - in_ready = !skid_valid, taken from a register with no combinational dependence on out_ready.
  - Main empty + accept: entry goes to main.
  - Main full + retire + accept: incoming entry goes to main.
  - Main full + no retire + accept: incoming entry goes to skid.
  - Main full, skid full + retire: skid moves to main, skid is cleared, in_ready rises next cycle.
  - The skid entry is never valid while main is invalid.
- SKID=0 datapath:
  - in_ready = !out_valid || out_ready, combinational.
  - No skid storage; the other rules are unchanged.
- Flush:
  - On an edge with flush=1, both entries become invalid, IRs = NOP_IR, data = 0.
  - flush has priority over a simultaneous accept, so that entry is dropped.
  - A simultaneous retire still counts as completed downstream.
  - in_ready = 1 in the following cycle.
  - flush does not alter stall_cnt.
- Stall counter:
  - Increments by 1 on each edge where out_valid && !out_ready.
  - Saturates at 2^CW-1; cleared only by reset.
- Bubble semantics: out_valid=0 implies out_ir=NOP_IR, so decode logic downstream sees a NOP.
- reset asserted mid-stream: all held entries are lost; no partial update survives.

Test Plan:
- Reset, SKID=1: assert reset mid-cycle, no clock edge needed -> out_valid=0, out_ir=0, out_data=0, stall_cnt=0, in_ready=1 after release.
- Streaming: 8 entries, ir=0x1000_0000+i and data=i, in_valid and out_ready held 1 -> out_ir sequence 0x1000_0000..0x1000_0007, one per cycle, each 1 cycle after its accept.
- Backpressure, SKID=1: out_ready=0, push A then B -> in_ready=0 after B, out=A stable, stall_cnt increments each cycle. Raise out_ready -> A then B out on consecutive cycles; in_ready=1 the cycle after the skid drains.
- Flush with simultaneous input: main=A, skid=B, flush=1 and in_valid=1 with C -> next cycle out_valid=0, out_ir=NOP_IR, in_ready=1; C never appears.
- Saturation, CW=3: hold out_valid=1, out_ready=0 for 10 cycles -> stall_cnt reads 1..7 then stays 7.
- SKID=0 mode: main full, out_ready=0 -> in_ready=0 in the same cycle. Raise out_ready with in_valid=1 -> in_ready=1 combinationally and the new entry replaces the retiring one at the edge.
